// File: rtl/mips_pipe_pkg.sv
// Purpose : shared constants for the MIPS pipeline: control-bundle layout and
//           operand-forwarding select encodings.
// Latency : n/a (definitions only).
// Backpressure: n/a.
// Contents: CTRL_W, CTRL_* bit indices, FWD_* select codes, sat_inc32 helper.
package mips_pipe_pkg;

   // Control bundle, MSB first:
   // REG_WRITE, MEM_READ, MEM_WRITE, MEM_TO_REG, ALU_SRC, REG_DST, ALU_OP[3:0]
   localparam int CTRL_W          = 10;
   localparam int CTRL_REG_WRITE  = 9;
   localparam int CTRL_MEM_READ   = 8;
   localparam int CTRL_MEM_WRITE  = 7;
   localparam int CTRL_MEM_TO_REG = 6;
   localparam int CTRL_ALU_SRC    = 5;
   localparam int CTRL_REG_DST    = 4;
   localparam int CTRL_ALU_OP     = 0;   // LSB of the 4-bit ALU_OP field
   localparam int CTRL_ALU_OP_W   = 4;

   // EX operand mux selects; 2'b11 is never produced.
   localparam logic [1:0] FWD_REG = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   // Saturating increment for 32-bit event counters.
   function automatic logic [31:0] sat_inc32(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/id_ex_fwd_stage_fwd_sel.sv
// Purpose : forwarding-select generator for one EX operand; the EX/MEM stage
//           beats MEM/WB so the youngest producer wins. r0 never forwards.
// Latency : purely combinational.
// Backpressure: none.
// Ports   : valid (EX holds a real instr), src (EX source reg),
//           mem_dst/mem_we (EX/MEM writer), wb_dst/wb_we (MEM/WB writer),
//           sel (FWD_REG / FWD_WB / FWD_MEM).
module fwd_sel
   import mips_pipe_pkg::*;
#(
   parameter int REG_AW = 5
) (
   input  logic              valid,
   input  logic [REG_AW-1:0] src,
   input  logic [REG_AW-1:0] mem_dst,
   input  logic              mem_we,
   input  logic [REG_AW-1:0] wb_dst,
   input  logic              wb_we,
   output logic [1:0]        sel
);

   always_comb begin
      sel = FWD_REG;
      if (valid && mem_we && (mem_dst != '0) && (mem_dst == src)) begin
         sel = FWD_MEM;
      end else if (valid && wb_we && (wb_dst != '0) && (wb_dst == src)) begin
         sel = FWD_WB;
      end
   end

endmodule

// File: rtl/id_ex_fwd_stage.sv
// Purpose : ID/EX pipeline register with EX forwarding selects and load-use
//           hazard detection (one-cycle front-end stall plus bubble).
// Latency : ID fields appear on ex_* one clock after sampling; fwd_a/fwd_b/stall
//           are combinational in the current cycle.
// Backpressure: stall holds PC and IF/ID for one cycle per load-use; flush wins
//           over stall and turns the ID instruction into a bubble.
// Config  : `WB_BYPASS_EN -- when defined, a same-cycle MEM/WB write to ID_RS/ID_RT
//           is captured instead of the register-file read data.
// Ports   : clk, rst_n (async, active low); id_* decoded instruction; flush;
//           mem_dst/mem_reg_write, wb_dst/wb_reg_write/wb_data (downstream
//           writers); ex_* registered operands/control; fwd_a/fwd_b; stall;
//           stall_cnt (saturating bubble count).
module id_ex_fwd_stage
   import mips_pipe_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic [REG_AW-1:0] id_rd,
   input  logic [DATA_W-1:0] id_rs_data,
   input  logic [DATA_W-1:0] id_rt_data,
   input  logic [DATA_W-1:0] id_imm,
   input  logic [CTRL_W-1:0] id_ctrl,
   input  logic              flush,
   input  logic [REG_AW-1:0] mem_dst,
   input  logic              mem_reg_write,
   input  logic [REG_AW-1:0] wb_dst,
   input  logic              wb_reg_write,
   input  logic [DATA_W-1:0] wb_data,
   output logic              ex_valid,
   output logic [DATA_W-1:0] ex_rs_data,
   output logic [DATA_W-1:0] ex_rt_data,
   output logic [DATA_W-1:0] ex_imm,
   output logic [REG_AW-1:0] ex_rt,
   output logic [REG_AW-1:0] ex_dst,
   output logic [CTRL_W-1:0] ex_ctrl,
   output logic [1:0]        fwd_a,
   output logic [1:0]        fwd_b,
   output logic              stall,
   output logic [31:0]       stall_cnt
);

   logic [REG_AW-1:0] ex_rs;
   logic              load_use;
   logic [DATA_W-1:0] rs_cap;
   logic [DATA_W-1:0] rt_cap;

   // A load in EX cannot forward its result until it reaches MEM, so any ID
   // consumer of its destination must wait one cycle.
   assign load_use = ex_valid && ex_ctrl[CTRL_MEM_READ] && (ex_dst != '0) &&
                     id_valid && ((ex_dst == id_rs) || (ex_dst == id_rt));

   // A taken branch discards the ID instruction anyway; holding the front end
   // would only delay the redirect.
   assign stall = load_use && !flush;

`ifdef WB_BYPASS_EN
   // The register file returns stale data when read and written in the same
   // cycle, so take the writeback value directly.
   always_comb begin
      rs_cap = id_rs_data;
      rt_cap = id_rt_data;
      if (wb_reg_write && (wb_dst != '0) && (wb_dst == id_rs)) rs_cap = wb_data;
      if (wb_reg_write && (wb_dst != '0) && (wb_dst == id_rt)) rt_cap = wb_data;
   end
`else
   logic unused_wb_data;
   assign unused_wb_data = ^wb_data;
   assign rs_cap = id_rs_data;
   assign rt_cap = id_rt_data;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_valid   <= 1'b0;
         ex_ctrl    <= '0;
         ex_rs_data <= '0;
         ex_rt_data <= '0;
         ex_imm     <= '0;
         ex_rs      <= '0;
         ex_rt      <= '0;
         ex_dst     <= '0;
         stall_cnt  <= '0;
      end else if (flush || load_use) begin
         // Bubble: data fields keep their old contents, only valid/ctrl matter.
         ex_valid <= 1'b0;
         ex_ctrl  <= '0;
         if (!flush) stall_cnt <= sat_inc32(stall_cnt);
      end else begin
         ex_valid   <= id_valid;
         ex_ctrl    <= id_ctrl;
         ex_rs_data <= rs_cap;
         ex_rt_data <= rt_cap;
         ex_imm     <= id_imm;
         ex_rs      <= id_rs;
         ex_rt      <= id_rt;
         ex_dst     <= id_ctrl[CTRL_REG_DST] ? id_rd : id_rt;
      end
   end

   fwd_sel #(.REG_AW(REG_AW)) u_fwd_a (
      .valid   (ex_valid),
      .src     (ex_rs),
      .mem_dst (mem_dst),
      .mem_we  (mem_reg_write),
      .wb_dst  (wb_dst),
      .wb_we   (wb_reg_write),
      .sel     (fwd_a)
   );

   fwd_sel #(.REG_AW(REG_AW)) u_fwd_b (
      .valid   (ex_valid),
      .src     (ex_rt),
      .mem_dst (mem_dst),
      .mem_we  (mem_reg_write),
      .wb_dst  (wb_dst),
      .wb_we   (wb_reg_write),
      .sel     (fwd_b)
   );

endmodule
